bin_to_bcd: RTL and testbench
=============================

BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 The block SHALL have parameter BIN_W, default 27, giving the binary input width.
REQ-002 The block SHALL have parameter DIG_N, default 8, giving the number of BCD digits produced (two 4-digit display groups).
REQ-003 sys_clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to convert bin_in; sampled on a rising edge.
REQ-006 bin_in  input  BIN_W  unsigned binary value; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse; bcd_out and ovf are updated in the same cycle.
REQ-009 bcd_out  output  4*DIG_N  packed BCD result; digit 0 = bits [3:0] (least significant), digit DIG_N-1 = most significant nibble.
REQ-010 ovf  output  1  high when the captured value exceeds 10^DIG_N - 1.

Function
REQ-011 The FSM SHALL have states IDLE, CONV and DONE; DONE SHALL last exactly one cycle.
REQ-012 In IDLE or DONE, start=1 SHALL capture bin_in into a shift register, clear the BCD scratch register, clear the bit counter and enter CONV; call this edge k.
REQ-013 start SHALL be ignored in CONV; a held-high start SHALL produce back-to-back conversions, one every BIN_W+1 cycles.
REQ-014 Each CONV edge SHALL perform one double-dabble step: add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one bit.
REQ-015 After BIN_W steps (edge k+BIN_W), the FSM SHALL enter DONE, load bcd_out and ovf, and drive done=1 for that single cycle.
REQ-016 busy SHALL be 1 from edge k until edge k+BIN_W, and 0 in IDLE and DONE.
REQ-017 The bit counter SHALL be $clog2(BIN_W+1) bits wide and SHALL not wrap within a conversion.
REQ-018 If the captured value > 10^DIG_N - 1, ovf SHALL be 1 and bcd_out SHALL saturate to all digits 9; otherwise ovf SHALL be 0.
REQ-019 The overflow compare SHALL be made on the value captured at edge k, not on a live bin_in.
REQ-020 bcd_out and ovf SHALL hold their values between done pulses; changes on bin_in SHALL not affect them.
REQ-021 Scratch arithmetic SHALL be confined to 4-bit digits; a corrected digit SHALL never exceed 4'd15 before the shift.

Reset
REQ-022 Assertion of sys_rst (low) SHALL immediately force: state IDLE, busy=0, done=0, bcd_out=0, ovf=0, counter=0, scratch=0.
REQ-023 Reset during CONV SHALL abort the conversion; no done pulse SHALL follow reset release.
REQ-024 After reset release, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE/CONV/DONE), the digit width constant 4, and the add-3 threshold 5.
REQ-026 A combinational sub-module bcd_add3 (4-bit in, 4-bit out) SHALL perform digit correction and SHALL be instantiated DIG_N times.
REQ-027 bcd_out SHALL connect directly to the downstream dynamic display's digit inputs, with no additional register stage.

Verification
REQ-028 bin_in=0, start pulse -> done exactly 27 cycles after the accepting edge; bcd_out=0x00000000; ovf=0; busy high for 27 cycles.
REQ-029 bin_in=12_345_678 -> bcd_out=0x12345678; ovf=0.
REQ-030 bin_in=99_999_999 -> bcd_out=0x99999999, ovf=0; then bin_in=100_000_000 -> bcd_out=0x99999999, ovf=1.
REQ-031 start held high with bin_in changing every cycle -> a capture occurs only at the IDLE/DONE edges; done pulses every 28 cycles; each result matches the value present at its capture edge.
REQ-032 Reset asserted 10 cycles into the conversion of 54_321 -> all outputs 0 immediately; no done after release; the next start of 54_321 -> bcd_out=0x00054321.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  // 10^n, elaboration-time only; used to derive the largest representable value.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
  import bin_to_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADD3_THRESH) digit_o = digit_i + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one bit per cycle, result and overflow
// flag registered on the single-cycle DONE state.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W = 27,
  parameter int DIG_N = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     start,
  input  logic [BIN_W-1:0]         bin_in,
  output logic                     busy,
  output logic                     done,
  output logic [DIGIT_W*DIG_N-1:0] bcd_out,
  output logic                     ovf,
  output state_e                   dbg_state
);

  localparam int BCD_W = DIGIT_W * DIG_N;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = pow10(DIG_N) - 64'd1;
  localparam logic [BCD_W-1:0] SAT_VAL = {DIG_N{4'h9}};

  // Handshake: start is sampled on every rising edge while IDLE or DONE; a high
  // sample captures bin_in. busy covers the BIN_W shift cycles, done pulses for
  // one cycle with bcd_out/ovf already valid, and the outputs hold until the next done.

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   corr;

  for (genvar g = 0; g < DIG_N; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          bin_d      = bin_in;
          scr_d      = '0;
          cnt_d      = '0;
          // Overflow is judged on the captured value; the shift register is consumed.
          ovf_pend_d = 64'(bin_in) > MAX_VAL;
          state_d    = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        {scr_d, bin_d} = {corr, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = ST_DONE;
          bcd_d   = ovf_pend_q ? SAT_VAL : scr_d;
          ovf_d   = ovf_pend_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy      = (state_q == ST_CONV);
  assign done      = (state_q == ST_DONE);
  assign bcd_out   = bcd_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd: reset, latency, value table, hold, back-to-back, abort.
module tb_bin_to_bcd;
  import bin_to_bcd_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        start   = 1'b0;
  logic [26:0] bin_in  = '0;
  logic        busy, done, ovf;
  logic [31:0] bcd_out;
  state_e      dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  bin_to_bcd #(.BIN_W(27), .DIG_N(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  // One start pulse; returns cycles from the accepting edge to done and busy cycles seen.
  task automatic convert(input logic [26:0] v, output int lat, output int busy_cnt);
    @(negedge sys_clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start    = 1'b0;
    bin_in   = ~v;
    lat      = 0;
    busy_cnt = 0;
    while (lat < 100 && !done) begin
      if (busy) busy_cnt++;
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    vec_cnt++;
    if ({busy, done, ovf, bcd_out} !== 35'd0 || dbg_state !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL reset_state: busy=%b done=%b ovf=%b bcd=%h st=%0d, need all 0 / IDLE",
               busy, done, ovf, bcd_out, dbg_state);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    vec_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL post_release_idle: busy=%b done=%b st=%0d", busy, done, dbg_state);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    convert(27'd0, lat, bc);
    vec_cnt++;
    if (lat !== 27) begin err_cnt++; $display("FAIL zero_latency: got %0d need 27", lat); end
    vec_cnt++;
    if (bc !== 27) begin err_cnt++; $display("FAIL zero_busy_cycles: got %0d need 27", bc); end
    vec_cnt++;
    if (bcd_out !== 32'h0 || ovf !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL zero_result: bcd=%h ovf=%b busy=%b need 00000000/0/0", bcd_out, ovf, busy);
    end
  endtask

  task automatic test_values();
    logic [26:0] vin  [9];
    logic [31:0] vexp [9];
    logic        vovf [9];
    int lat, bc;
    vin[0] = 27'd12345678;  vexp[0] = 32'h12345678; vovf[0] = 1'b0;
    vin[1] = 27'd99999999;  vexp[1] = 32'h99999999; vovf[1] = 1'b0;
    vin[2] = 27'd100000000; vexp[2] = 32'h99999999; vovf[2] = 1'b1;
    vin[3] = 27'd134217727; vexp[3] = 32'h99999999; vovf[3] = 1'b1;
    vin[4] = 27'd9;         vexp[4] = 32'h00000009; vovf[4] = 1'b0;
    vin[5] = 27'd10;        vexp[5] = 32'h00000010; vovf[5] = 1'b0;
    vin[6] = 27'd1000;      vexp[6] = 32'h00001000; vovf[6] = 1'b0;
    vin[7] = 27'd55555555;  vexp[7] = 32'h55555555; vovf[7] = 1'b0;
    vin[8] = 27'd80706050;  vexp[8] = 32'h80706050; vovf[8] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      convert(vin[i], lat, bc);
      vec_cnt++;
      if (lat !== 27 || bcd_out !== vexp[i] || ovf !== vovf[i]) begin
        err_cnt++;
        $display("FAIL value_%0d: in=%0d lat=%0d bcd=%h ovf=%b need lat=27 bcd=%h ovf=%b",
                 i, vin[i], lat, bcd_out, ovf, vexp[i], vovf[i]);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      bin_in = 27'(i * 7777 + 1);
    end
    @(negedge sys_clk);
    vec_cnt++;
    if (bcd_out !== 32'h80706050 || ovf !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL hold: bcd=%h ovf=%b done=%b st=%0d need 80706050/0/0/IDLE",
               bcd_out, ovf, done, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    int    n_done;
    bit    exp_done;
    logic [31:0] exp_bcd;
    int    n;
    n_done = 0;
    @(negedge sys_clk);
    for (int c = 0; c <= 90; c++) begin
      start  = 1'b1;
      bin_in = 27'(1000 * c + 7);
      @(posedge sys_clk);
      @(negedge sys_clk);
      exp_done = (c == 27) || (c == 55) || (c == 83);
      vec_cnt++;
      if (done !== exp_done || busy !== !exp_done) begin
        err_cnt++;
        $display("FAIL b2b_timing_c%0d: done=%b busy=%b need done=%b", c, done, busy, exp_done);
      end
      if (exp_done && done) begin
        exp_bcd = (c == 27) ? 32'h00000007 : (c == 55) ? 32'h00028007 : 32'h00056007;
        n_done++;
        vec_cnt++;
        if (bcd_out !== exp_bcd || ovf !== 1'b0) begin
          err_cnt++;
          $display("FAIL b2b_value_c%0d: bcd=%h ovf=%b need %h/0", c, bcd_out, ovf, exp_bcd);
        end
      end
    end
    start = 1'b0;
    vec_cnt++;
    if (n_done !== 3) begin err_cnt++; $display("FAIL b2b_count: got %0d need 3", n_done); end
    n = 0;
    while (n < 60 && (busy || done)) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      n++;
    end
    vec_cnt++;
    if (n >= 60 || bcd_out !== 32'h00084007) begin
      err_cnt++;
      $display("FAIL b2b_drain: cycles=%0d bcd=%h need <60 / 00084007", n, bcd_out);
    end
  endtask

  task automatic test_reset_abort();
    int seen, lat, bc;
    @(negedge sys_clk);
    start  = 1'b1;
    bin_in = 27'd54321;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (10) @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, done, ovf, bcd_out} !== 35'd0 || dbg_state !== ST_IDLE) begin
      err_cnt++;
      $display("FAIL abort_reset: busy=%b done=%b ovf=%b bcd=%h st=%0d need all 0 / IDLE",
               busy, done, ovf, bcd_out, dbg_state);
    end
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (done || busy) seen++;
    end
    vec_cnt++;
    if (seen !== 0) begin err_cnt++; $display("FAIL abort_no_done: active cycles=%0d need 0", seen); end
    convert(27'd54321, lat, bc);
    vec_cnt++;
    if (lat !== 27 || bcd_out !== 32'h00054321 || ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL abort_restart: lat=%0d bcd=%h ovf=%b need 27/00054321/0", lat, bcd_out, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
